// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: parametrised UART receiver with optional parity, 1 or 2 stop
// bits, false-start rejection, per-frame parity/framing flags and break
// detection. Hands one payload word per frame to the command parser with a
// single-cycle valid strobe.
//
// Build option: define UART_RX_MAJORITY_EN to take each bit decision as the
// 2-of-3 majority of three samples around mid-bit (completion moves +2 cycles).
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | line idle, waiting for rxs=0 with receive enabled
// S_START      | timing the start bit, mid-bit high = false start
// S_DATA       | shifting in PAYLOAD_BITS data bits, LSB first
// S_PARITY     | sampling and checking the parity bit (PARITY != 0 only)
// S_STOP       | sampling stop bit(s); completes at the last stop sample
// S_BREAK_WAIT | break reported, waiting for the line to return high

module uart_rx_cfg #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_parity_err,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break,
  output logic                    uart_rx_busy
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;
  localparam int HALF           = CYCLES_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
  // decision is taken one cycle after the third sample at HALF+1
  localparam int SMP_AT         = HALF + 2;
`else
  localparam int SMP_AT         = HALF;
`endif

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SMP   = CNT_W'(SMP_AT);
  localparam logic [3:0]       DATA_LAST = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  // odd parity expects data ^ parity bit == 1, even expects 0
  localparam logic             PAR_ODD   = (PARITY == 1);
  localparam logic             HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK_WAIT
  } state_t;

  state_t                  state;
  logic                    rx_meta;
  logic                    rxs;
  logic                    smp;
  logic [CNT_W-1:0]        cycle_cnt;
  logic [3:0]              bit_cnt;
  logic [PAYLOAD_BITS-1:0] shreg;
  logic                    par_bit;
  logic                    par_err;
  logic                    frm_err;

  logic                    at_smp;
  logic                    at_wrap;
  logic                    frm_now;
  logic                    brk_now;
  logic                    par_calc;

  // two-flop synchroniser on the asynchronous RX pin, idles high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] maj_q;

  // history of the last three rxs values; at SMP_AT it holds HALF-1..HALF+1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      maj_q <= 3'b111;
    end else begin
      maj_q <= {maj_q[1:0], rxs};
    end
  end

  assign smp = (maj_q[0] & maj_q[1]) | (maj_q[0] & maj_q[2]) | (maj_q[1] & maj_q[2]);
`else
  assign smp = rxs;
`endif

  assign at_smp   = (cycle_cnt == CNT_SMP);
  assign at_wrap  = (cycle_cnt == CNT_LAST);
  // framing error including the stop bit being sampled right now
  assign frm_now  = frm_err | ~smp;
  assign brk_now  = frm_now & ~(|shreg) & (~HAS_PAR | ~par_bit);
  assign par_calc = ((^shreg) ^ smp) != PAR_ODD;

  assign uart_rx_busy = (state != S_IDLE);

  // receive FSM, bit timing and registered frame outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= S_IDLE;
      cycle_cnt          <= '0;
      bit_cnt            <= '0;
      shreg              <= '0;
      par_bit            <= 1'b0;
      par_err            <= 1'b0;
      frm_err            <= 1'b0;
      uart_rx_valid      <= 1'b0;
      uart_rx_data       <= '0;
      uart_rx_parity_err <= 1'b0;
      uart_rx_frame_err  <= 1'b0;
      uart_rx_break      <= 1'b0;
    end else begin
      uart_rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          cycle_cnt <= '0;
          bit_cnt   <= '0;
          par_bit   <= 1'b0;
          par_err   <= 1'b0;
          frm_err   <= 1'b0;
          if (!rxs && uart_rx_en) begin
            state <= S_START;
          end
        end

        S_START: begin
          cycle_cnt <= at_wrap ? '0 : cycle_cnt + 1'b1;
          if (at_smp && smp) begin
            // line went back high before mid-bit: glitch, not a start bit
            state <= S_IDLE;
          end else if (at_wrap) begin
            state <= S_DATA;
          end
        end

        S_DATA: begin
          cycle_cnt <= at_wrap ? '0 : cycle_cnt + 1'b1;
          if (at_smp) begin
            shreg <= {smp, shreg[PAYLOAD_BITS-1:1]};
          end
          if (at_wrap) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        S_PARITY: begin
          cycle_cnt <= at_wrap ? '0 : cycle_cnt + 1'b1;
          if (at_smp) begin
            par_bit <= smp;
            par_err <= par_calc;
          end
          if (at_wrap) begin
            state <= S_STOP;
          end
        end

        S_STOP: begin
          cycle_cnt <= at_wrap ? '0 : cycle_cnt + 1'b1;
          if (at_smp) begin
            frm_err <= frm_now;
            if (bit_cnt == STOP_LAST) begin
              // finish at the last stop sample so back-to-back frames fit
              uart_rx_valid      <= 1'b1;
              uart_rx_data       <= shreg;
              uart_rx_parity_err <= par_err;
              uart_rx_frame_err  <= frm_now;
              uart_rx_break      <= brk_now;
              cycle_cnt          <= '0;
              bit_cnt            <= '0;
              state              <= brk_now ? S_BREAK_WAIT : S_IDLE;
            end
          end else if (at_wrap) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        S_BREAK_WAIT: begin
          // a held-low line must not produce a stream of zero frames
          cycle_cnt <= '0;
          if (rxs) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: two instances (8N1 and 8E2) at 10 cycles/bit,
// table-driven frames with a scoreboard, plus hand sequences for reset,
// break, false start, receive disable and (when built with
// UART_RX_MAJORITY_EN) a mid-bit glitch.
`timescale 1ns/1ps

module tb_uart_rx_cfg;

  localparam int CLK_HZ = 50_000_000;
  localparam int BR     = 5_000_000;
  localparam int CPB    = 10;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT_EXTRA = 2;
`else
  localparam int LAT_EXTRA = 0;
`endif
  localparam int LAT_NOM = 2 + 1 + 9 * CPB + CPB / 2 + 1 + LAT_EXTRA;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       en = 1'b1;
  logic       rxd_a = 1'b1;
  logic       rxd_b = 1'b1;

  logic       valid_a, perr_a, ferr_a, brk_a, busy_a;
  logic [7:0] data_a;
  logic       valid_b, perr_b, ferr_b, brk_b, busy_b;
  logic [7:0] data_b;

  always #10 clk = ~clk;

  uart_rx_cfg #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BR), .PAYLOAD_BITS(8), .PARITY(0), .STOP_BITS(1)
  ) u_a (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_a), .uart_rx_en(en),
    .uart_rx_valid(valid_a), .uart_rx_data(data_a),
    .uart_rx_parity_err(perr_a), .uart_rx_frame_err(ferr_a),
    .uart_rx_break(brk_a), .uart_rx_busy(busy_a)
  );

  uart_rx_cfg #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BR), .PAYLOAD_BITS(8), .PARITY(2), .STOP_BITS(2)
  ) u_b (
    .clk(clk), .resetn(resetn), .uart_rxd(rxd_b), .uart_rx_en(en),
    .uart_rx_valid(valid_b), .uart_rx_data(data_b),
    .uart_rx_parity_err(perr_b), .uart_rx_frame_err(ferr_b),
    .uart_rx_break(brk_b), .uart_rx_busy(busy_b)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       brk;
  } exp_t;

  typedef struct {
    bit         sel;       // 0 = 8N1 instance, 1 = 8E2 instance
    logic [7:0] d;
    bit         pflip;     // send the wrong parity bit
    bit         stop_low;  // drive the last stop bit low
    int         gap;       // idle cycles after the frame
    logic       perr;
    logic       ferr;
    logic       brk;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  vec_t vecs[10];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   t_valid_a = 0;
  int   n_valid_a = 0;
  int   n_valid_b = 0;
  logic pv_a = 1'b0;
  logic pv_b = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cmp_frame(input string tag, input logic [7:0] d, input logic pe,
                           input logic fe, input logic bk, input exp_t e);
    check({tag, "_data"}, 32'(d), 32'(e.data));
    check({tag, "_parity_err"}, 32'(pe), 32'(e.perr));
    check({tag, "_frame_err"}, 32'(fe), 32'(e.ferr));
    check({tag, "_break"}, 32'(bk), 32'(e.brk));
  endtask

  // scoreboard consumers, sampled on the falling edge
  always @(negedge clk) begin
    if (resetn && valid_a) begin : mon_a
      exp_t e;
      n_valid_a++;
      t_valid_a = cyc;
      check("a_strobe_width", 32'(pv_a), 32'd0);
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_valid actual=valid data=%0h required=no valid", data_a);
      end else begin
        e = q_a.pop_front();
        cmp_frame("a", data_a, perr_a, ferr_a, brk_a, e);
      end
    end
    pv_a = valid_a;
  end

  always @(negedge clk) begin
    if (resetn && valid_b) begin : mon_b
      exp_t e;
      n_valid_b++;
      check("b_strobe_width", 32'(pv_b), 32'd0);
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_valid actual=valid data=%0h required=no valid", data_b);
      end else begin
        e = q_b.pop_front();
        cmp_frame("b", data_b, perr_b, ferr_b, brk_b, e);
      end
    end
    pv_b = valid_b;
  end

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rxd_b = v;
    else rxd_a = v;
    repeat (n) @(negedge clk);
  endtask

  // frame with even parity and two stop bits on instance b, 8N1 on a
  task automatic send(input bit sel, input logic [7:0] d, input bit pflip, input bit stop_low);
    drive(sel, 1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(sel, d[i], CPB);
    if (sel) begin
      drive(sel, (^d) ^ pflip, CPB);
      drive(sel, 1'b1, CPB);
    end
    drive(sel, ~stop_low, CPB);
    if (sel) rxd_b = 1'b1;
    else rxd_a = 1'b1;
  endtask

  task automatic push(input bit sel, input logic [7:0] d, input logic pe, input logic fe,
                      input logic bk);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    e.brk  = bk;
    if (sel) q_b.push_back(e);
    else q_a.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((q_a.size() + q_b.size()) != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("drain", 32'(q_a.size() + q_b.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n0;
    int lat;

    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h81, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h81, 1'b1, 1'b0, 20, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b1, 20, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 1'b1, 1'b1, 20, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 8'h7E, 1'b0, 1'b0, 0,  1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 8'hFF, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0};

    resetn = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_a", {20'd0, valid_a, data_a, perr_a, ferr_a, brk_a, busy_a}, 32'd0);
    check("reset_b", {20'd0, valid_b, data_b, perr_b, ferr_b, brk_b, busy_b}, 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      push(vecs[i].sel, vecs[i].d, vecs[i].perr, vecs[i].ferr, vecs[i].brk);
      t0 = cyc;
      send(vecs[i].sel, vecs[i].d, vecs[i].pflip, vecs[i].stop_low);
      if (i == 0) begin
        lat = t_valid_a - t0;
        check("latency_a", 32'(lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1), 32'd1);
      end
      repeat (vecs[i].gap) @(negedge clk);
    end
    wait_drain(300);

    // reset in the middle of data bit 2 of 0x12, then a clean 0x34
    drive(1'b0, 1'b0, CPB);
    drive(1'b0, 1'b0, CPB);
    drive(1'b0, 1'b1, CPB);
    drive(1'b0, 1'b0, 5);
    resetn = 1'b0;
    rxd_a = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mid_a", {20'd0, valid_a, data_a, perr_a, ferr_a, brk_a, busy_a}, 32'd0);
    check("reset_mid_b", {20'd0, valid_b, data_b, perr_b, ferr_b, brk_b, busy_b}, 32'd0);
    resetn = 1'b1;
    repeat (20) @(negedge clk);
    n0 = n_valid_a;
    push(1'b0, 8'h34, 1'b0, 1'b0, 1'b0);
    send(1'b0, 8'h34, 1'b0, 1'b0);
    wait_drain(100);
    repeat (20) @(negedge clk);
    check("reset_one_valid", 32'(n_valid_a - n0), 32'd1);

    // line held low for 40 bit times: one break frame, then hold in BREAK_WAIT
    n0 = n_valid_a;
    push(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    rxd_a = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    check("break_busy_held", 32'(busy_a), 32'd1);
    rxd_a = 1'b1;
    repeat (6) @(negedge clk);
    check("break_busy_release", 32'(busy_a), 32'd0);
    repeat (30) @(negedge clk);
    check("break_one_valid", 32'(n_valid_a - n0), 32'd1);
    check("break_queue", 32'(q_a.size()), 32'd0);

    // 3-cycle low pulse: start seen, rejected at mid-bit
    n0 = n_valid_a;
    rxd_a = 1'b0;
    repeat (3) @(negedge clk);
    rxd_a = 1'b1;
    @(negedge clk);
    check("false_start_busy", 32'(busy_a), 32'd1);
    repeat (10) @(negedge clk);
    check("false_start_idle", 32'(busy_a), 32'd0);
    repeat (100) @(negedge clk);
    check("false_start_no_valid", 32'(n_valid_a - n0), 32'd0);

    // receive disabled: a full 0xFF frame is ignored
    en = 1'b0;
    n0 = n_valid_a;
    send(1'b0, 8'hFF, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("disabled_no_valid", 32'(n_valid_a - n0), 32'd0);
    check("disabled_idle", 32'(busy_a), 32'd0);
    en = 1'b1;
    repeat (5) @(negedge clk);

`ifdef UART_RX_MAJORITY_EN
    // 0x00 with a one-cycle high glitch on the sampled mid-point of data bit 0
    push(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, CPB);
    drive(1'b0, 1'b0, 6);
    drive(1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 3);
    for (int i = 1; i < 8; i++) drive(1'b0, 1'b0, CPB);
    drive(1'b0, 1'b1, CPB);
    wait_drain(100);
`endif

    repeat (20) @(negedge clk);
    check("final_queues", 32'(q_a.size() + q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor UART receiver for the demo designs. Adds configurable payload width, optional odd/even parity, 1 or 2 stop bits, false-start rejection, and sticky-per-frame parity/framing error flags. Break detection is qualified by the framing error. Sits between the board RX pin and the debug/command parser, and hands off one byte (or word) per frame with a one-cycle valid strobe.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz.
BIT_RATE, 9600, line rate in bits/s. CYCLES_PER_BIT = CLK_HZ/BIT_RATE, which must be >= 8.
PAYLOAD_BITS, 8, data bits per frame, legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits checked, 1 or 2.

Ports:
clk  in  1  system clock.
resetn  in  1  asynchronous active-low reset.
uart_rxd  in  1  serial input, asynchronous to clk, idles high.
uart_rx_en  in  1  receive enable. When low, no new frame may start.
uart_rx_valid  out  1  one-cycle strobe: frame complete.
uart_rx_data  out  PAYLOAD_BITS  received payload, LSB first on the wire.
uart_rx_parity_err  out  1  parity mismatch in the last frame. Always 0 when PARITY=0.
uart_rx_frame_err  out  1  at least one stop bit sampled low in the last frame.
uart_rx_break  out  1  last frame was a break.
uart_rx_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, while resetn=0):
  - 2-flop synchroniser = 1, FSM = IDLE, all counters = 0.
  - uart_rx_data = 0, uart_rx_valid = 0, all error flags = 0, busy = 0.
- Synchroniser: two flops on uart_rxd, always running. "rxs" denotes the second flop. All decisions use rxs.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- Bit timing:
  - cycle_cnt counts 0..CYCLES_PER_BIT-1 in every state except IDLE and BREAK_WAIT, then wraps to 0 and advances the bit.
  - Sample point is cycle_cnt == CYCLES_PER_BIT/2. The sampled value is "smp".
- IDLE: when rxs=0 and uart_rx_en=1, go to START with cycle_cnt=0. With uart_rx_en=0, stay in IDLE. Deasserting uart_rx_en mid-frame does not abort the frame.
- START:
  - At the sample point, smp=1 is a false start: return to IDLE immediately, no valid strobe, outputs unchanged.
  - Otherwise go to DATA at the bit wrap.
- DATA:
  - Shift smp in at MSB-first position of a PAYLOAD_BITS shift register, so the first wire bit ends up in data[0].
  - bit_cnt counts 0..PAYLOAD_BITS-1.
  - After the last bit wrap, go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - At the sample point, par_err = (XOR of data bits ^ smp) != (PARITY==1 ? 1 : 0). Odd parity requires an odd total number of 1s.
  - At the bit wrap, go to STOP.
- STOP:
  - Sample each stop bit. Any smp=0 sets frm_err.
  - Completion happens at the sample point of the last stop bit; the FSM does not wait for the end of the stop bit, to allow back-to-back frames.
- Completion: in the cycle after the completion sample, all of the following happen together:
  - uart_rx_valid=1 for exactly one cycle.
  - uart_rx_data, uart_rx_parity_err and uart_rx_frame_err update.
  - uart_rx_break = frm_err AND all data bits 0 AND (PARITY==0 OR parity bit sampled 0).
  - Outputs hold until the next completion. The error flags always describe the most recent frame.
- Next state after completion:
  - If uart_rx_break=1, go to BREAK_WAIT. Stay there until rxs=1, then IDLE. Prevents a held-low line generating repeated frames.
  - Otherwise go to IDLE. A new start bit is then accepted on the next cycle that rxs=0.
- Latency: falling edge on uart_rxd to uart_rx_valid = 2 (sync) + 1 + (1+PAYLOAD_BITS+(PARITY!=0)+STOP_BITS-1)*CYCLES_PER_BIT + CYCLES_PER_BIT/2 + 1 cycles, ±1.
- Widths: cycle_cnt is $clog2(CYCLES_PER_BIT)+1 bits; bit_cnt is 4 bits. No counter wraps past its terminal value.
- Reset mid-frame: immediate return to the reset state. No partial frame is reported.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each smp is the 2-of-3 majority of rxs sampled at cycle_cnt = CYCLES_PER_BIT/2-1, CYCLES_PER_BIT/2 and CYCLES_PER_BIT/2+1. The decision is used one cycle after the last sample, so the completion strobe shifts +2 cycles. A single-cycle glitch at the mid-bit point is rejected.
- Undefined: single sample at CYCLES_PER_BIT/2, exactly as described in Behaviour.

Test Plan:
All scenarios use CLK_HZ=50_000_000, BIT_RATE=5_000_000 (10 cycles/bit).
1. PARITY=0, STOP_BITS=1, send 0xA5 -> single valid pulse, data=0xA5, parity_err=0, frame_err=0, break=0. Back-to-back 0x3C with no idle gap -> second valid, data=0x3C.
2. PARITY=2, send 0x81 with correct parity bit 0 -> parity_err=0. Resend 0x81 with parity bit 1 -> parity_err=1, data=0x81, valid still pulses.
3. STOP_BITS=2, send 0x55 with the second stop bit low -> frame_err=1, break=0, data=0x55.
4. Hold uart_rxd low for 40 bit times -> exactly one valid with data=0x00, frame_err=1, break=1. busy stays high until uart_rxd returns high. No further valid pulses.
5. Low pulse of 3 cycles on idle line -> false start, no valid, busy returns low within 10 cycles. With uart_rx_en=0, a full 0xFF frame is ignored.
6. Assert resetn=0 mid-data-bit of frame 0x12, release, then send 0x34 -> outputs all 0 during reset, only one valid, data=0x34. With UART_RX_MAJORITY_EN defined, a 1-cycle high glitch at the mid-bit of data bit 0 of 0x00 -> data=0x00.
